bar_height_ctrl: RTL and testbench

//  Frame-synchronous scheduler that turns the two vote counts into the top-line values of the two bars in the VGA bar chart.

---
 rtl/bar_height_ctrl_pkg.sv | 22 ++
 rtl/bar_height_ctrl_if.sv | 25 ++
 rtl/bar_height_ctrl_divider.sv | 67 ++++++
 rtl/bar_height_ctrl.sv | 129 ++++++++++++
 tb/tb_bar_height_ctrl.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/bar_height_ctrl_pkg.sv
// Shared constants and types for the bar-chart display path.
package bar_chart_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        PUB  = 2'd3
    } state_t;

    // Default bar geometry (line numbers).
    localparam int BAR_TOP_DEF  = 40;
    localparam int BAR_BASE_DEF = 600;
    localparam int SPAN_DEF     = BAR_BASE_DEF - BAR_TOP_DEF;

    // Grid/axis lines shared with the VGA renderer.
    localparam int AXIS_LINE    = BAR_BASE_DEF;
    localparam int GRID_STEP    = 56;
    localparam int GRID_LINES   = SPAN_DEF / GRID_STEP;

endpackage

// File: rtl/bar_height_ctrl_if.sv
// Frame-start, vote-count and height signals between the VGA logic and the scheduler.
interface bar_height_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int H_W   = 10
);
    logic             frame_start;
    logic [CNT_W-1:0] in1;
    logic [CNT_W-1:0] in2;
    logic [H_W-1:0]   height1;
    logic [H_W-1:0]   height2;
    logic             busy;
    logic             upd;

    // Side that starts frames and supplies the counts.
    modport master (
        output frame_start, in1, in2,
        input  height1, height2, busy, upd
    );

    // Scheduler side.
    modport slave (
        input  frame_start, in1, in2,
        output height1, height2, busy, upd
    );
endinterface

// File: rtl/bar_height_ctrl_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, NUM_W cycles per divide.
module seq_divider #(
    parameter int NUM_W = 26,
    parameter int CNT_W = 16,
    parameter int Q_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [CNT_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quot
);
    localparam int CW = $clog2(NUM_W);

    logic [NUM_W-1:0] r_num;   // numerator shifts out the top, quotient shifts in the bottom
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_den;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [CNT_W:0]   w_trial;
    logic             w_ge;
    logic [CNT_W-1:0] w_rem_next;
    logic             w_last;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        w_trial    = {r_rem, r_num[NUM_W-1]};
        w_ge       = (w_trial >= {1'b0, r_den});
        w_rem_next = w_ge ? CNT_W'(w_trial - {1'b0, r_den}) : w_trial[CNT_W-1:0];
        w_last     = (r_cnt == CW'(NUM_W - 1));
    end

    // Load on start, then iterate NUM_W times.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_num  <= num;
            r_den  <= den;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_num  <= {r_num[NUM_W-2:0], w_ge};
            r_rem  <= w_rem_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge writes the final quotient bit,
    // so the consumer can move on without an extra idle cycle.
    assign busy = r_busy;
    assign done = r_busy && w_last;
    assign quot = r_num[Q_W-1:0];

endmodule

// File: rtl/bar_height_ctrl.sv
// Per-frame scheduler computing the top lines of the two vote bars.
module bar_height_ctrl
    import bar_chart_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int H_W      = 10,
    parameter int BAR_TOP  = BAR_TOP_DEF,
    parameter int BAR_BASE = BAR_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    bar_height_ctrl_if.slave   bus
);
    localparam int NUM_W = CNT_W + H_W;
    localparam int SPAN  = BAR_BASE - BAR_TOP;
    localparam logic [H_W-1:0] TOP_H  = H_W'(BAR_TOP);
    localparam logic [H_W-1:0] BASE_H = H_W'(BAR_BASE);

    state_t           r_state;
    state_t           w_next;

    logic [H_W-1:0]   r_h1;
    logic [H_W-1:0]   r_h2;
    logic [H_W-1:0]   r_pend1;
    logic [H_W-1:0]   r_pend2;
    logic             r_lose1;
    logic             r_div;
    logic             r_upd;

    logic             w_1_wins;
    logic [CNT_W-1:0] w_lo;
    logic [CNT_W-1:0] w_hi;
    logic             w_special;
    logic [H_W-1:0]   w_pend1;
    logic [H_W-1:0]   w_pend2;
    logic [NUM_W-1:0] w_num;
    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [H_W-1:0]   w_quot;

    // Case decode on the live counts; results are captured on the LOAD edge.
    always_comb begin
        w_1_wins  = (bus.in1 > bus.in2);
        w_lo      = w_1_wins ? bus.in2 : bus.in1;
        w_hi      = w_1_wins ? bus.in1 : bus.in2;
        w_special = (bus.in1 == bus.in2) || (w_lo == '0);
        w_num     = NUM_W'(SPAN) * NUM_W'(w_lo);
        w_pend1   = TOP_H;
        w_pend2   = TOP_H;
        if (bus.in1 == '0 && bus.in2 == '0) begin
            w_pend1 = BASE_H;
            w_pend2 = BASE_H;
        end else if (bus.in1 != bus.in2) begin
            // Loser parks at the baseline; overwritten at PUB in the divide case.
            w_pend1 = w_1_wins ? TOP_H : BASE_H;
            w_pend2 = w_1_wins ? BASE_H : TOP_H;
        end
        w_div_start = (r_state == LOAD) && !w_special;
    end

    seq_divider #(
        .NUM_W (NUM_W),
        .CNT_W (CNT_W),
        .Q_W   (H_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (w_div_start),
        .num   (w_num),
        .den   (w_hi),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .quot  (w_quot)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; frame_start outside IDLE is dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.frame_start) w_next = LOAD;
            LOAD: w_next = w_special ? PUB : DIV;
            DIV:  if (w_div_done || !w_div_busy) w_next = PUB;
            PUB:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Snapshot of the frame's decision and atomic publish of both heights.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h1    <= TOP_H;
            r_h2    <= TOP_H;
            r_pend1 <= TOP_H;
            r_pend2 <= TOP_H;
            r_lose1 <= 1'b0;
            r_div   <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (r_state == LOAD) begin
                r_pend1 <= w_pend1;
                r_pend2 <= w_pend2;
                r_lose1 <= !w_1_wins;
                r_div   <= !w_special;
            end
            if (r_state == PUB) begin
                r_upd <= 1'b1;
                r_h1  <= (r_div &&  r_lose1) ? BASE_H - w_quot : r_pend1;
                r_h2  <= (r_div && !r_lose1) ? BASE_H - w_quot : r_pend2;
            end
        end
    end

    assign bus.height1 = r_h1;
    assign bus.height2 = r_h2;
    assign bus.busy    = (r_state != IDLE);
    assign bus.upd     = r_upd;

endmodule

// File: tb/tb_bar_height_ctrl.sv
// Directed self-checking bench for bar_height_ctrl.
module tb_bar_height_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bar_height_ctrl_if #(.CNT_W(16), .H_W(10)) bus ();

    bar_height_ctrl #(
        .CNT_W    (16),
        .H_W      (10),
        .BAR_TOP  (40),
        .BAR_BASE (600)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present counts and a one-cycle frame_start; returns just after E0.
    task automatic start_frame(input logic [15:0] a, input logic [15:0] b);
        bus.in1         = a;
        bus.in2         = b;
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic frame_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input int e1, input int e2);
        start_frame(a, b);
        tick(1);
        check({tag, "_busy_E1"}, bus.busy, 1);
        tick(26);
        check({tag, "_busy_E27"}, bus.busy, 1);
        check({tag, "_upd_E27"}, bus.upd, 0);
        tick(1);
        check({tag, "_upd_E28"}, bus.upd, 1);
        check({tag, "_h1"}, bus.height1, e1);
        check({tag, "_h2"}, bus.height2, e2);
        check({tag, "_busy_E28"}, bus.busy, 0);
        tick(1);
        check({tag, "_upd_E29"}, bus.upd, 0);
    endtask

    task automatic frame_special(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input int e1, input int e2);
        start_frame(a, b);
        tick(1);
        check({tag, "_upd_E1"}, bus.upd, 0);
        tick(1);
        check({tag, "_upd_E2"}, bus.upd, 1);
        check({tag, "_h1"}, bus.height1, e1);
        check({tag, "_h2"}, bus.height2, e2);
        tick(1);
        check({tag, "_upd_E3"}, bus.upd, 0);
        check({tag, "_busy_E3"}, bus.busy, 0);
    endtask

    initial begin
        int ups;
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.in1         = '0;
        bus.in2         = '0;
        tick(3);
        check("rst_h1", bus.height1, 40);
        check("rst_h2", bus.height2, 40);
        check("rst_busy", bus.busy, 0);
        check("rst_upd", bus.upd, 0);
        rst = 1'b0;
        tick(2);

        // T1: 560*50/100 = 280 -> 600-280 = 320
        frame_div("t1", 16'd100, 16'd50, 40, 320);
        // T2: 560*3/7 = 240 -> 360
        frame_div("t2", 16'd3, 16'd7, 360, 40);
        // T3
        frame_special("t3a", 16'd0, 16'd0, 600, 600);
        frame_special("t3b", 16'd25, 16'd25, 40, 40);
        // T4: 560/65535 = 0
        frame_div("t4a", 16'd65535, 16'd1, 40, 600);
        frame_special("t4b", 16'd0, 16'd9, 600, 40);

        // T5: inputs changed and frame_start repeated mid-divide
        start_frame(16'd100, 16'd50);
        tick(5);
        bus.in1         = 16'd1;
        bus.in2         = 16'd1000;
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
        ups = 0;
        for (int e = 7; e <= 40; e++) begin
            tick(1);
            if (bus.upd) ups++;
            if (e == 28) begin
                check("t5_upd_E28", bus.upd, 1);
                check("t5_h1", bus.height1, 40);
                check("t5_h2", bus.height2, 320);
            end
        end
        check("t5_upd_count", ups, 1);
        check("t5_busy_end", bus.busy, 0);

        // T6: reset during divide, then a normal frame (560/4 = 140 -> 460)
        start_frame(16'd3, 16'd7);
        tick(11);
        rst = 1'b1;
        tick(1);
        check("t6_rst_h1", bus.height1, 40);
        check("t6_rst_h2", bus.height2, 40);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_upd", bus.upd, 0);
        rst = 1'b0;
        tick(2);
        frame_div("t6b", 16'd1, 16'd4, 460, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
